// File: rtl/cb_control_gen_if.sv
// Sample-in / control-out bundle of the control-bounded front end.
//   in_data, in_valid  : sample offered by the source
//   in_ready           : front end accepts in_data this cycle
//   ctrl, ctrl_valid   : per-cycle comparator decisions, one bit per stage
//   frame_start        : marks the first ctrl of each OSR period
//   underrun, overload : one-cycle status pulses
// master = sample source / ctrl consumer, slave = the front end itself.
interface cb_control_gen_if #(
  parameter int unsigned N    = 3,
  parameter int unsigned IN_W = 16
);
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           ctrl;
  logic                   ctrl_valid;
  logic                   frame_start;
  logic                   underrun;
  logic                   overload;

  modport master (
    output in_data, in_valid,
    input  in_ready, ctrl, ctrl_valid, frame_start, underrun, overload
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ctrl, ctrl_valid, frame_start, underrun, overload
  );
endinterface

// File: rtl/cb_control_gen.sv
// Control-bounded A/D front end: chain of N saturating fixed-point integrators,
// one comparator and one +/-FB feedback term per stage. Takes one sample per OSR
// clocks and emits one N-bit control vector every clock.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cb_control_gen_if.slave (sample handshake in, control stream out)
// Outputs are registered except bus.in_ready.
module cb_control_gen #(
  parameter int unsigned N       = 3,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned ST_W    = 24,
  parameter int unsigned OSR     = 32,
  parameter int unsigned G_SHIFT = 2,
  parameter int unsigned FB      = 2 ** (ST_W - 3)
) (
  input logic             clk,
  input logic             rst,
  cb_control_gen_if.slave bus
);

  localparam int unsigned CntW    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned SumW    = ST_W + 2;
  localparam int unsigned A0Shift = ST_W - IN_W - 2;

  localparam logic [CntW-1:0]        CntLast = CntW'(OSR - 1);
  localparam logic signed [SumW-1:0] FbPos   = SumW'(FB);
  localparam logic signed [SumW-1:0] FbNeg   = -FbPos;
  localparam logic signed [SumW-1:0] SatMax  = {3'b000, {(ST_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin  = {3'b111, {(ST_W-1){1'b0}}};
  localparam logic signed [ST_W-1:0] XMax    = {1'b0, {(ST_W-1){1'b1}}};
  localparam logic signed [ST_W-1:0] XMin    = {1'b1, {(ST_W-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic signed [IN_W-1:0] u_q;
  logic signed [ST_W-1:0] x_q [N];

  logic [N-1:0]           ctrl_q;
  logic                   ctrl_valid_q;
  logic                   frame_start_q;
  logic                   underrun_q;
  logic                   overload_q;

  // Integrator datapath, evaluated from the current registers.
  logic [N-1:0]           s;
  logic [N-1:0]           sat_hit;
  logic signed [ST_W-1:0] a_in [N];
  logic signed [SumW-1:0] sum  [N];
  logic signed [ST_W-1:0] x_d  [N];

  always_comb begin
    // Stage-0 input: sample scaled up to leave 2 bits of headroom in the state.
    a_in[0] = ST_W'(u_q) <<< A0Shift;
    for (int k = 1; k < N; k++) begin
      a_in[k] = x_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      s[k]       = ~x_q[k][ST_W-1];
      sum[k]     = SumW'(x_q[k]) + SumW'(a_in[k] >>> G_SHIFT) - (s[k] ? FbPos : FbNeg);
      sat_hit[k] = 1'b0;
      x_d[k]     = sum[k][ST_W-1:0];
      if (sum[k] > SatMax) begin
        x_d[k]     = XMax;
        sat_hit[k] = 1'b1;
      end else if (sum[k] < SatMin) begin
        x_d[k]     = XMin;
        sat_hit[k] = 1'b1;
      end
    end
  end

  assign bus.in_ready = (state_q == StIdle) || (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      u_q           <= '0;
      for (int k = 0; k < N; k++) begin
        x_q[k] <= '0;
      end
      ctrl_q        <= '0;
      ctrl_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overload_q    <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overload_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            u_q     <= bus.in_data;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          for (int k = 0; k < N; k++) begin
            x_q[k] <= x_d[k];
          end
          ctrl_q        <= s;
          ctrl_valid_q  <= 1'b1;
          overload_q    <= |sat_hit;
          frame_start_q <= (cnt_q == '0);
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            // Period end: take a fresh sample or keep reusing the old one.
            if (bus.in_valid) begin
              u_q <= bus.in_data;
            end else begin
              underrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.ctrl_valid  = ctrl_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.overload    = overload_q;

endmodule

// File: doc/cb_control_gen.md
# cb_control_gen

Digital behavioural model of the control-bounded A/D front end: a fixed-point chain-of-integrators with one comparator and one feedback term per stage. It accepts input samples over a valid/ready handshake and emits one N-bit control vector per clock, the stream consumed by the batch estimator. The block is the transmit end of the control-signal interface. It serves as a synthesizable stimulus source for estimator simulation and for on-chip loopback tests.

## Interface
- N, 3: number of integrator stages, which is also the number of control bits.
- IN_W, 16: signed input sample width.
- ST_W, 24: signed integrator state width. Requires ST_W ≥ IN_W+4.
- OSR, 32: clock cycles per input sample. Equals the estimator batch depth. Power of two.
- G_SHIFT, 2: integrator gain is 2^-G_SHIFT, applied as an arithmetic right shift.
- FB, 2^(ST_W-3): feedback magnitude, a positive integer below 2^(ST_W-2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts in_data this cycle.
- ctrl  out  N  control vector. Bit k is the comparator decision of stage k.
- ctrl_valid  out  1  ctrl holds a valid decision.
- frame_start  out  1  one-cycle pulse marking the first ctrl of each OSR period.
- underrun  out  1  one-cycle pulse: a period ended with no new sample available.
- overload  out  1  one-cycle pulse: at least one stage saturated this cycle.

## Operation
- States:
  - IDLE: after reset; integrators frozen.
  - RUN: integrate every cycle.
- Registers:
  - u_reg: the current sample.
  - cnt: log2(OSR) bits.
  - x[0..N-1]: ST_W-bit integrator states.
- Reset values:
  - Outputs: ctrl=0, ctrl_valid=0, frame_start=0, underrun=0, overload=0; in_ready=1 (combinational, since the block resets into IDLE).
  - Internal: x[k]=0, u_reg=0, cnt=0, state=IDLE.
- in_ready is combinational: 1 in IDLE, 1 in RUN when cnt==OSR-1, otherwise 0.
- A sample is accepted when in_valid && in_ready. u_reg loads in_data.
  - In IDLE, acceptance moves the state to RUN with cnt=0.
- Per RUN cycle, with s[k] = (x[k] ≥ 0) taken from the current registers:
  - a[0] = sext(u_reg) <<< (ST_W-IN_W-2).
  - a[k] = x[k-1] for k ≥ 1, using the pre-update value.
  - x[k] <= sat(x[k] + (a[k] >>> G_SHIFT) − (s[k] ? FB : −FB)).
  - ctrl[k] <= s[k]; ctrl_valid <= 1; cnt <= cnt+1, wrapping at OSR.
- sat clamps the full-precision sum (ST_W+2 bits) to [−2^(ST_W−1), 2^(ST_W−1)−1].
  - overload <= OR over k of the clamp events in that cycle.
- frame_start <= 1 on the cycle after any RUN cycle in which cnt==0. It aligns with the ctrl of the period's first decision.
- Period end (cnt==OSR-1), no valid sample:
  - underrun <= 1 for one cycle.
  - u_reg is held and reused; the state stays RUN.
- Period end, in_valid high: u_reg updates; the new sample applies from the next cycle (cnt==0).
- in_valid outside the period end has no effect. Data is not accepted or buffered.
- IDLE is only re-entered through rst.
- Reset assertion mid-run immediately clears all state and outputs to their reset values. The first accepted sample after release starts a fresh period at cnt=0.

## Timing
- ctrl lags its decision by 1 cycle. The decision and the feedback use the same cycle's s.
- Latency from sample acceptance to the first ctrl reflecting it:
  - IDLE accept at cycle t: first RUN cycle t+1, ctrl_valid and frame_start high at t+2.
  - RUN accept: the new sample drives the stage-0 update one cycle later.
- Sustained throughput: one sample per OSR cycles, one ctrl vector every cycle.
- All outputs are registered except in_ready.
- The design contains no multiplier: only shifts, adds and a compare per stage, which is enough for single-cycle closure.

## Test plan
Parameters: N=3, IN_W=16, ST_W=24, OSR=32, G_SHIFT=2, FB=2^21 unless stated.

- **Reset:** assert rst for 3 cycles, async mid-cycle → ctrl=0, ctrl_valid=0, frame_start=0, underrun=0, overload=0, in_ready=1 immediately.
- **Zero input:** accept in_data=0, then hold in_valid with 0 → ctrl[0] sequence 1,0,1,0…; exactly 16 ones per 32-cycle frame; no overload.
- **Handshake cadence:** in_valid held high → exactly one acceptance per 32 cycles, in_ready high only at cnt==31, frame_start every 32 cycles, first frame_start 2 cycles after the IDLE accept.
- **Underrun:** deassert in_valid across one period end → underrun pulses once on the cycle after cnt==31, u_reg reused, ctrl stream uninterrupted, no frame_start gap.
- **Full scale:** in_data=+32767 constant → stage-0 ones density 20±1 per frame; in_data=−32768 → 12±1; no overload.
- **Saturation and mid-run reset:**
  - FB=0 override with in_data=+32767 → overload pulses once x saturates; x[k] never wraps sign.
  - Then assert rst mid-frame → all outputs return to reset values in the same cycle, and the next accept restarts at cnt=0.
